// File: rtl/cplx_div_seq_if.sv
// Handshake and operand/result bundle for the sequential Q4.4 complex divider.
interface cplx_div_seq_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] aj;
  logic [7:0] b;
  logic [7:0] bj;
  logic [7:0] c;
  logic [7:0] cj;
  logic       busy;
  logic       done;
  logic       div0;

  modport master (
    output start, a, aj, b, bj,
    input  c, cj, busy, done, div0
  );

  modport slave (
    input  start, a, aj, b, bj,
    output c, cj, busy, done, div0
  );
endinterface

// File: rtl/cplx_div_seq.sv
// Sequential Q4.4 complex divider: q = (a + j*aj) / (b + j*bj), 22-cycle latency,
// built from two 20-step restoring dividers sharing the divisor |b|^2 + |bj|^2.
module cplx_div_seq (
  input  logic           clk,
  input  logic           rst,
  cplx_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, DIV, FIN} state_t;

  state_t             state_q, state_d;
  logic signed [7:0]  a_q, a_d, aj_q, aj_d, b_q, b_d, bj_q, bj_d;
  logic [15:0]        d_q, d_d;
  logic               sr_q, sr_d, si_q, si_d;
  logic [19:0]        dr_q, dr_d, di_q, di_d;
  logic [16:0]        rr_q, rr_d, ri_q, ri_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [7:0]         c_q, c_d, cj_q, cj_d;
  logic               div0_q, div0_d, done_q, done_d;

  logic signed [15:0] p_ab, p_ajbj, p_ajb, p_abj, p_bb, p_bjbj;
  logic signed [16:0] nr, ni;
  logic [16:0]        mag_nr, mag_ni;
  logic [15:0]        d_calc;
  logic [17:0]        step_r, step_i;

  // One restoring step: returns {quotient bit, new remainder}.
  function automatic logic [17:0] div_step(input logic [16:0] rem, input logic msb,
                                           input logic [15:0] den);
    logic [17:0] trial;
    trial = {rem, msb};
    if (trial >= {2'b00, den})
      div_step = {1'b1, 17'(trial - {2'b00, den})};
    else
      div_step = {1'b0, 17'(trial)};
  endfunction

  function automatic logic [7:0] saturate(input logic [19:0] mag, input logic neg);
    if (neg)
      saturate = (mag >= 20'd128) ? 8'h80 : 8'(~mag[7:0] + 8'd1);
    else
      saturate = (mag > 20'd127) ? 8'h7F : mag[7:0];
  endfunction

  always_comb begin
    p_ab   = a_q * b_q;
    p_ajbj = aj_q * bj_q;
    p_ajb  = aj_q * b_q;
    p_abj  = a_q * bj_q;
    p_bb   = b_q * b_q;
    p_bjbj = bj_q * bj_q;
    nr     = {p_ab[15], p_ab} + {p_ajbj[15], p_ajbj};
    ni     = {p_ajb[15], p_ajb} - {p_abj[15], p_abj};
    mag_nr = nr[16] ? (~nr + 17'd1) : nr;
    mag_ni = ni[16] ? (~ni + 17'd1) : ni;
    d_calc = $unsigned(p_bb) + $unsigned(p_bjbj);
    step_r = div_step(rr_q, dr_q[19], d_q);
    step_i = div_step(ri_q, di_q[19], d_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    aj_d    = aj_q;
    b_d     = b_q;
    bj_d    = bj_q;
    d_d     = d_q;
    sr_d    = sr_q;
    si_d    = si_q;
    dr_d    = dr_q;
    di_d    = di_q;
    rr_d    = rr_q;
    ri_d    = ri_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cj_d    = cj_q;
    div0_d  = div0_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = $signed(bus.a);
          aj_d    = $signed(bus.aj);
          b_d     = $signed(bus.b);
          bj_d    = $signed(bus.bj);
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Pre-shift by 4 so the integer quotient lands directly in Q4.4 LSBs.
        d_d     = d_calc;
        sr_d    = nr[16];
        si_d    = ni[16];
        dr_d    = 20'({mag_nr, 4'b0000});
        di_d    = 20'({mag_ni, 4'b0000});
        rr_d    = '0;
        ri_d    = '0;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        // Dividend registers double as quotient shift registers.
        rr_d  = step_r[16:0];
        ri_d  = step_i[16:0];
        dr_d  = {dr_q[18:0], step_r[17]};
        di_d  = {di_q[18:0], step_i[17]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19)
          state_d = FIN;
      end
      FIN: begin
        if (d_q == 16'd0) begin
          c_d    = 8'h00;
          cj_d   = 8'h00;
          div0_d = 1'b1;
        end else begin
          c_d    = saturate(dr_q, sr_q);
          cj_d   = saturate(di_q, si_q);
          div0_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      aj_q    <= '0;
      b_q     <= '0;
      bj_q    <= '0;
      d_q     <= '0;
      sr_q    <= 1'b0;
      si_q    <= 1'b0;
      dr_q    <= '0;
      di_q    <= '0;
      rr_q    <= '0;
      ri_q    <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      cj_q    <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      aj_q    <= aj_d;
      b_q     <= b_d;
      bj_q    <= bj_d;
      d_q     <= d_d;
      sr_q    <= sr_d;
      si_q    <= si_d;
      dr_q    <= dr_d;
      di_q    <= di_d;
      rr_q    <= rr_d;
      ri_q    <= ri_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cj_q    <= cj_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  assign bus.c    = c_q;
  assign bus.cj   = cj_q;
  assign bus.div0 = div0_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != IDLE);

endmodule
